// File: rtl/icache_responder.sv
// icache_responder
// Direct-mapped instruction cache sitting between the fetch stage and the
// external instruction memory. A hit returns the instruction word in the same
// cycle. A miss raises stall and then refills the whole line from backing
// memory using a req/ack handshake, one word per ack, in order 0..LINE_WORDS-1.
//
// Ports
//   clock      rising-edge clock
//   reset      synchronous, active-high reset
//   if_PC      fetch address (bits [1:0] ignored)
//   flush      invalidate all lines; aborts an in-flight refill
//   if_instr   instruction word for if_PC, valid when stall = 0
//   stall      miss / refill / flush in progress; fetch holds if_PC
//   mem_req    backing-memory word read request
//   mem_addr   word-aligned read address
//   mem_ack    memory returns mem_rdata for mem_addr this cycle
//   mem_rdata  read data, sampled when mem_req & mem_ack
module icache_responder #(
  parameter int unsigned INDEX_BITS = 4,
  parameter int unsigned OFF_BITS   = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] if_PC,
  input  logic        flush,
  output logic [31:0] if_instr,
  output logic        stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned LINES      = 1 << INDEX_BITS;
  localparam int unsigned LINE_WORDS = 1 << OFF_BITS;
  localparam int unsigned TAG_BITS   = 32 - INDEX_BITS - OFF_BITS - 2;
  localparam logic [OFF_BITS-1:0] LAST_WORD = OFF_BITS'(LINE_WORDS - 1);

  typedef enum logic {IDLE, REFILL} state_t;

  state_t                state;
  logic [LINES-1:0]      valid;
  logic [TAG_BITS-1:0]   tag_mem  [LINES];
  logic [31:0]           data_mem [LINES][LINE_WORDS];

  logic [TAG_BITS-1:0]   miss_tag;
  logic [INDEX_BITS-1:0] miss_index;
  logic [OFF_BITS-1:0]   word_cnt;
  logic [OFF_BITS-1:0]   next_word;

  logic [OFF_BITS-1:0]   pc_word;
  logic [INDEX_BITS-1:0] pc_index;
  logic [TAG_BITS-1:0]   pc_tag;
  logic                  hit;
  logic                  unused_pc_bits;

  assign pc_word        = if_PC[OFF_BITS+1:2];
  assign pc_index       = if_PC[OFF_BITS+INDEX_BITS+1:OFF_BITS+2];
  assign pc_tag         = if_PC[31:OFF_BITS+INDEX_BITS+2];
  assign unused_pc_bits = ^if_PC[1:0];

  assign hit       = valid[pc_index] && (tag_mem[pc_index] == pc_tag);
  assign next_word = word_cnt + 1'b1;

  // Outputs are forced quiet while reset is held, independent of state.
  always_comb begin
    stall    = 1'b0;
    if_instr = '0;
    if (!reset) begin
      if (state == REFILL || flush || !hit) begin
        stall = 1'b1;
      end else begin
        if_instr = data_mem[pc_index][pc_word];
      end
    end
  end

  // Control FSM with registered memory-side outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      valid      <= '0;
      word_cnt   <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      miss_tag   <= '0;
      miss_index <= '0;
    end else begin
      if (flush) begin
        valid <= '0;
      end
      case (state)
        IDLE: begin
          if (!hit && !flush) begin
            state      <= REFILL;
            miss_tag   <= pc_tag;
            miss_index <= pc_index;
            word_cnt   <= '0;
            mem_req    <= 1'b1;
            mem_addr   <= {pc_tag, pc_index, {OFF_BITS{1'b0}}, 2'b00};
          end
        end
        REFILL: begin
          // Flush has priority over the last-word ack, so an aborted line
          // is never validated.
          if (flush) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            word_cnt <= '0;
          end else if (mem_ack) begin
            if (word_cnt == LAST_WORD) begin
              valid[miss_index] <= 1'b1;
              state             <= IDLE;
              mem_req           <= 1'b0;
              word_cnt          <= '0;
            end else begin
              word_cnt <= next_word;
              mem_addr <= {miss_tag, miss_index, next_word, 2'b00};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data and tag arrays carry no reset; a line is only usable once valid.
  always_ff @(posedge clock) begin
    if (!reset && state == REFILL && mem_ack) begin
      data_mem[miss_index][word_cnt] <= mem_rdata;
      if (word_cnt == LAST_WORD && !flush) begin
        tag_mem[miss_index] <= miss_tag;
      end
    end
  end

endmodule
